cmp_sort_ctrl: RTL and testbench
================================

Name: cmp_sort_ctrl

Overview:
- Sequencer that collects N unsigned W-bit words, sorts them in place, then streams them out.
- All ordering decisions come from one shared instance of the team's 4-bit magnitude comparator (ports Data_in_A, Data_in_B, less, equal, greater).
- The block is the scheduler for that comparator: it chooses which element pair the comparator sees each cycle and acts on its result.
- Sits between a valid/ready producer and a valid/ready consumer.

Parameters:
- N, 8, number of words per batch (2..16).
- W, 4, word width; must equal the comparator width.
- DESCEND, 0, 0 = ascending sort, 1 = descending sort.
- CW, 8, width of the swap counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a new batch; sampled only in IDLE.
- in_valid  in  1  producer has a word.
- in_data  in  W  input word.
- in_ready  out  1  block accepts a word this cycle.
- out_valid  out  1  out_data holds a sorted word.
- out_data  out  W  sorted output word.
- out_ready  in  1  consumer takes the word.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last output word is transferred.
- swap_count  out  CW  swaps in the last or current batch; saturates at all-ones.

Behaviour:
- Reset (async, any state): state=IDLE; in_ready, out_valid, busy and done = 0; out_data = 0; swap_count = 0; all N storage registers = 0; index and pass counters = 0.
- IDLE: outputs idle. If start=1, go to LOAD, clear swap_count, clear the load index.
- LOAD: in_ready=1.
  - On each in_valid&in_ready, write mem[idx] = in_data and increment idx.
  - After the N-th accept, go to SORT with pass=0, i=0, swapped_flag=0.
  - in_valid=0 stalls without penalty.
- SORT: one compare-and-swap per cycle.
  - Comparator inputs: Data_in_A=mem[i], Data_in_B=mem[i+1].
  - Swap condition: greater (DESCEND=0) or less (DESCEND=1). equal never swaps, so the sort is stable.
  - On swap: exchange mem[i] and mem[i+1] at the clock edge, set swapped_flag, increment swap_count (saturating).
  - Pass i runs 0..N-2-pass.
  - At the end of a pass: if swapped_flag=0 or pass=N-2, go to OUTPUT. Otherwise increment pass, reset i=0, clear swapped_flag.
  - Latency: minimum N-1 cycles (already sorted); maximum N(N-1)/2 cycles. For N=8 that is 7 and 28.
- OUTPUT: out_valid=1, out_data=mem[oidx].
  - On out_valid&out_ready, increment oidx.
  - out_data is held stable while out_ready=0.
  - After the N-th transfer: done=1 for exactly one cycle, go to IDLE, out_valid=0.
- start asserted outside IDLE is ignored, including start on the same cycle as done.
- in_ready and out_valid are never high together.
- swap_count holds its value in IDLE until the next start.
- Reset asserted mid-LOAD, SORT or OUTPUT aborts the batch immediately. There is no partial output after reset is released.
- in_data is unsigned; no arithmetic wider than W on data. Index counters are clog2(N) bits, and the pass counter is too.

Decomposition:
- Shared package cmp_pkg:
  - state enum: IDLE, LOAD, SORT, OUTPUT.
  - localparam IDXW = clog2(N).
  - the swap-condition function, selected by DESCEND.
- One sub-module instance: comparator (the existing block), shared and driven only by SORT muxing.
- Storage stays a flat register array inside cmp_sort_ctrl; no separate RAM module.

Test Plan:
1. Reverse order: load 15,14,13,12,11,10,9,8 -> output 8..15 ascending; swap_count=28; SORT lasts exactly 28 cycles; done one pulse.
2. Presorted: load 1,2,3,4,5,6,7,8 -> SORT lasts 7 cycles (early exit); swap_count=0; output unchanged.
3. Duplicates with DESCEND=1: load 10,12,10,15,11,10,0,12 -> output 15,12,12,11,10,10,10,0.
4. Handshake stress: random in_valid gaps and out_ready held low 5 cycles mid-output -> out_data stable during the stall; no lost or duplicated words; in_ready=0 outside LOAD.
5. Reset mid-SORT: async rst 3 cycles into SORT, then a new start with 3,1,2,0,7,6,5,4 -> all outputs 0 during reset; second batch outputs 0..7 correctly; swap_count reflects the second batch only.
6. start pulses during LOAD and OUTPUT -> no effect; exactly N words in and N out per batch.

Source files
------------

// File: rtl/cmp_sort_ctrl_pkg.sv
// Shared definitions for the comparator-driven sort sequencer.
// Contents:
//   state_e    - sequencer states (IDLE, LOAD, SORT, OUTPUT)
//   IDXW       - index/pass counter width for the default batch size
//   idx_width  - index/pass counter width for any batch size
//   swap_cond  - decides from the comparator flags whether a pair is out of order
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    SORT   = 2'd2,
    OUTPUT = 2'd3
  } state_e;

  localparam int N_DEFAULT = 8;
  localparam int IDXW      = $clog2(N_DEFAULT);

  function automatic int idx_width(input int n);
    return $clog2(n);
  endfunction

  // Equal never swaps, which keeps the bubble sort stable.
  function automatic logic swap_cond(input logic descend, input logic lt,
                                     input logic eq, input logic gt);
    logic hit;
    if (descend) begin
      hit = lt;
    end else begin
      hit = gt;
    end
    return hit & ~eq;
  endfunction

endpackage

// File: rtl/cmp_sort_ctrl_comparator.sv
// Team magnitude comparator (unsigned).
// Ports:
//   Data_in_A, Data_in_B - operands
//   less, equal, greater - A<B, A==B, A>B
module cmp_sort_ctrl_comparator #(
  parameter int W = 4
) (
  input  logic [W-1:0] Data_in_A,
  input  logic [W-1:0] Data_in_B,
  output logic         less,
  output logic         equal,
  output logic         greater
);

  assign less    = (Data_in_A <  Data_in_B);
  assign equal   = (Data_in_A == Data_in_B);
  assign greater = (Data_in_A >  Data_in_B);

endmodule

// File: rtl/cmp_sort_ctrl.sv
// Collects N words from a valid/ready producer, bubble-sorts them in place
// using one shared comparator (one compare-and-swap per cycle, early exit on
// a clean pass), then streams them to a valid/ready consumer.
// Ports:
//   clk, rst             - clock, async active-high reset
//   start                - begin a batch (honoured only in IDLE)
//   in_valid/in_ready    - producer handshake, in_data word
//   out_valid/out_ready  - consumer handshake, out_data word
//   busy                 - high outside IDLE
//   done                 - one-cycle pulse after the last output transfer
//   swap_count           - saturating swap count of the current/last batch
module cmp_sort_ctrl
  import cmp_pkg::*;
#(
  parameter int N       = 8,
  parameter int W       = 4,
  parameter int DESCEND = 0,
  parameter int CW      = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          in_valid,
  input  logic [W-1:0]  in_data,
  output logic          in_ready,
  output logic          out_valid,
  output logic [W-1:0]  out_data,
  input  logic          out_ready,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] swap_count
);

  localparam int              IW        = idx_width(N);
  localparam logic [IW-1:0]   IDX_LAST  = IW'(N - 1);
  localparam logic [IW-1:0]   PASS_LAST = IW'(N - 2);
  localparam logic            DESC_BIT  = (DESCEND != 0);

  state_e          state_q;
  logic [W-1:0]    mem_q [N];
  logic [IW-1:0]   idx_q;      // load index in LOAD, output index in OUTPUT
  logic [IW-1:0]   pass_q;
  logic [IW-1:0]   i_q;
  logic            swapped_q;
  logic            in_ready_q;
  logic            out_valid_q;
  logic            busy_q;
  logic            done_q;
  logic [W-1:0]    out_data_q;
  logic [CW-1:0]   swap_cnt_q;

  logic [W-1:0]    cmp_a_s;
  logic [W-1:0]    cmp_b_s;
  logic            lt_s;
  logic            eq_s;
  logic            gt_s;
  logic            swap_s;
  logic            pass_end_s;
  logic [IW-1:0]   i_nxt_s;
  logic [W-1:0]    head_s;
  logic [CW-1:0]   swap_cnt_d;

  cmp_sort_ctrl_comparator #(.W(W)) u_cmp (
    .Data_in_A (cmp_a_s),
    .Data_in_B (cmp_b_s),
    .less      (lt_s),
    .equal     (eq_s),
    .greater   (gt_s)
  );

  // Comparator operand mux: only SORT drives a real pair.
  always_comb begin
    i_nxt_s = i_q + IW'(1);
    if (state_q == SORT) begin
      cmp_a_s = mem_q[i_q];
      cmp_b_s = mem_q[i_nxt_s];
    end else begin
      cmp_a_s = {W{1'b0}};
      cmp_b_s = {W{1'b0}};
    end
  end

  // Swap decision, pass boundary, saturating count and post-swap head word.
  always_comb begin
    swap_s     = (state_q == SORT) & swap_cond(DESC_BIT, lt_s, eq_s, gt_s);
    pass_end_s = (i_q == (PASS_LAST - pass_q));
    if (swap_cnt_q == {CW{1'b1}}) begin
      swap_cnt_d = swap_cnt_q;
    end else begin
      swap_cnt_d = swap_cnt_q + CW'(1);
    end
    // The final compare may swap element 0 on the same edge we leave SORT.
    if (swap_s && (i_q == {IW{1'b0}})) begin
      head_s = mem_q[1];
    end else begin
      head_s = mem_q[0];
    end
  end

  // Sequencer: state, storage, counters and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= {IW{1'b0}};
      pass_q      <= {IW{1'b0}};
      i_q         <= {IW{1'b0}};
      swapped_q   <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      out_data_q  <= {W{1'b0}};
      swap_cnt_q  <= {CW{1'b0}};
      for (int k = 0; k < N; k++) begin
        mem_q[k] <= {W{1'b0}};
      end
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // A start coinciding with the done pulse belongs to the old batch.
          if (start && !done_q) begin
            state_q    <= LOAD;
            swap_cnt_q <= {CW{1'b0}};
            idx_q      <= {IW{1'b0}};
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        LOAD: begin
          if (in_valid && in_ready_q) begin
            mem_q[idx_q] <= in_data;
            if (idx_q == IDX_LAST) begin
              state_q    <= SORT;
              in_ready_q <= 1'b0;
              pass_q     <= {IW{1'b0}};
              i_q        <= {IW{1'b0}};
              swapped_q  <= 1'b0;
            end else begin
              idx_q <= idx_q + IW'(1);
            end
          end
        end
        SORT: begin
          if (swap_s) begin
            mem_q[i_q]     <= cmp_b_s;
            mem_q[i_nxt_s] <= cmp_a_s;
            swap_cnt_q     <= swap_cnt_d;
          end
          if (pass_end_s) begin
            if (!(swapped_q || swap_s) || (pass_q == PASS_LAST)) begin
              state_q     <= OUTPUT;
              out_valid_q <= 1'b1;
              out_data_q  <= head_s;
              idx_q       <= {IW{1'b0}};
            end else begin
              pass_q    <= pass_q + IW'(1);
              i_q       <= {IW{1'b0}};
              swapped_q <= 1'b0;
            end
          end else begin
            i_q       <= i_nxt_s;
            swapped_q <= swapped_q | swap_s;
          end
        end
        OUTPUT: begin
          if (out_ready) begin
            if (idx_q == IDX_LAST) begin
              state_q     <= IDLE;
              out_valid_q <= 1'b0;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
            end else begin
              idx_q      <= idx_q + IW'(1);
              out_data_q <= mem_q[idx_q + IW'(1)];
            end
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign swap_count = swap_cnt_q;

endmodule

// File: tb/tb_cmp_sort_ctrl.sv
// Self-checking bench for cmp_sort_ctrl: one ascending and one descending
// instance share the stimulus; a select picks which one is active. Expected
// outputs come from a counting sort, swap counts from inversion counts, and
// SORT duration from the largest per-element displacement.
module tb_cmp_sort_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       sel;
  logic       in_valid;
  logic [3:0] in_data;
  logic       out_ready;

  logic       ir_a, ov_a, bz_a, dn_a, ir_d, ov_d, bz_d, dn_d;
  logic [3:0] od_a, od_d;
  logic [7:0] sc_a, sc_d;
  logic       ir, ov, bz, dn;
  logic [3:0] od;
  logic [7:0] sc;
  logic       start_a, start_d;

  int vectors = 0;
  int miscompares = 0;
  logic [3:0] w [8];

  always #5 clk = ~clk;

  assign start_a = start & ~sel;
  assign start_d = start & sel;

  cmp_sort_ctrl #(.N(8), .W(4), .DESCEND(0), .CW(8)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .in_valid(in_valid), .in_data(in_data),
    .in_ready(ir_a), .out_valid(ov_a), .out_data(od_a), .out_ready(out_ready),
    .busy(bz_a), .done(dn_a), .swap_count(sc_a));

  cmp_sort_ctrl #(.N(8), .W(4), .DESCEND(1), .CW(8)) dut_d (
    .clk(clk), .rst(rst), .start(start_d), .in_valid(in_valid), .in_data(in_data),
    .in_ready(ir_d), .out_valid(ov_d), .out_data(od_d), .out_ready(out_ready),
    .busy(bz_d), .done(dn_d), .swap_count(sc_d));

  always_comb begin
    if (sel) begin
      ir = ir_d; ov = ov_d; bz = bz_d; dn = dn_d; od = od_d; sc = sc_d;
    end else begin
      ir = ir_a; ov = ov_a; bz = bz_a; dn = dn_a; od = od_a; sc = sc_a;
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_in_ready"}, int'(ir_a) + int'(ir_d), 0);
    chk({tag, "_out_valid"}, int'(ov_a) + int'(ov_d), 0);
    chk({tag, "_busy"}, int'(bz_a) + int'(bz_d), 0);
    chk({tag, "_done"}, int'(dn_a) + int'(dn_d), 0);
    chk({tag, "_out_data"}, int'(od_a) + int'(od_d), 0);
    chk({tag, "_swap_count"}, int'(sc_a) + int'(sc_d), 0);
  endtask

  // Start a batch and feed w[] in, optionally with gaps and spurious starts.
  task automatic load_batch(input bit gaps, input bit noise);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("load_busy", int'(bz), 1);
    chk("load_in_ready", int'(ir), 1);
    chk("load_out_valid", int'(ov), 0);
    for (int k = 0; k < 8; k++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 3)) begin
          in_valid = 1'b0;
          @(negedge clk);
          chk("gap_in_ready", int'(ir), 1);
        end
      end
      in_valid = 1'b1;
      in_data  = w[k];
      start    = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b0;
    start    = 1'b0;
    chk("sort_in_ready", int'(ir), 0);
    chk("sort_busy", int'(bz), 1);
  endtask

  // Wait out SORT, drain the outputs and compare everything with the model.
  task automatic finish_batch(input bit desc, input int stall_at, input bit noise);
    int exp_q [$];
    int inv, kmax, passes, cycles, cnt, above;
    exp_q = {};
    for (int v = 0; v < 16; v++) begin
      int val;
      val = desc ? 15 - v : v;
      for (int j = 0; j < 8; j++) begin
        if (int'(w[j]) == val) exp_q.push_back(val);
      end
    end
    inv = 0; kmax = 0;
    for (int j = 0; j < 8; j++) begin
      above = 0;
      for (int i = 0; i < j; i++) begin
        if (desc ? (w[i] < w[j]) : (w[i] > w[j])) above++;
      end
      inv += above;
      if (above > kmax) kmax = above;
    end
    passes = (kmax + 1 < 7) ? kmax + 1 : 7;
    cycles = 0;
    for (int p = 0; p < passes; p++) cycles += 7 - p;

    cnt = 0;
    while (!ov && cnt < 200) begin
      cnt++;
      @(negedge clk);
    end
    chk("sort_cycles", cnt, cycles);
    if (cnt >= 200) return;

    for (int k = 0; k < 8; k++) begin
      if (k == stall_at) begin
        out_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          chk("stall_data", int'(od), exp_q[k]);
          chk("stall_valid", int'(ov), 1);
        end
      end
      chk("out_data", int'(od), exp_q[k]);
      chk("out_valid", int'(ov), 1);
      chk("out_in_ready", int'(ir), 0);
      out_ready = 1'b1;
      start     = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
    end
    out_ready = 1'b0;
    chk("done_pulse", int'(dn), 1);
    chk("done_out_valid", int'(ov), 0);
    chk("done_busy", int'(bz), 0);
    chk("swap_count", int'(sc), inv);
    start = noise;   // a start during the done cycle must be ignored
    @(negedge clk);
    start = 1'b0;
    chk("done_clear", int'(dn), 0);
    chk("idle_busy", int'(bz), 0);
    chk("idle_swap_hold", int'(sc), inv);
  endtask

  task automatic randomize_words();
    for (int j = 0; j < 8; j++) w[j] = 4'($urandom_range(0, 15));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; sel = 1'b0;
    in_valid = 1'b0; in_data = 4'd0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Reverse order, ascending.
    for (int j = 0; j < 8; j++) w[j] = 4'(15 - j);
    load_batch(1'b0, 1'b0);
    finish_batch(1'b0, -1, 1'b0);

    // Presorted: one clean pass.
    for (int j = 0; j < 8; j++) w[j] = 4'(j + 1);
    load_batch(1'b0, 1'b0);
    finish_batch(1'b0, -1, 1'b0);

    // Duplicates, descending instance.
    sel = 1'b1;
    w[0] = 4'd10; w[1] = 4'd12; w[2] = 4'd10; w[3] = 4'd15;
    w[4] = 4'd11; w[5] = 4'd10; w[6] = 4'd0;  w[7] = 4'd12;
    load_batch(1'b0, 1'b0);
    finish_batch(1'b1, -1, 1'b0);

    // Handshake stress: input gaps and a 5-cycle output stall.
    sel = 1'b0;
    randomize_words();
    load_batch(1'b1, 1'b0);
    finish_batch(1'b0, 3, 1'b0);

    // Spurious start pulses during LOAD, OUTPUT and the done cycle.
    sel = 1'b1;
    randomize_words();
    load_batch(1'b1, 1'b1);
    finish_batch(1'b1, 5, 1'b1);

    // Reset three cycles into SORT, then a fresh batch.
    sel = 1'b0;
    randomize_words();
    load_batch(1'b0, 1'b0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1 check_all_zero("async_reset");
    @(negedge clk);
    check_all_zero("held_reset");
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("post_reset");
    w[0] = 4'd3; w[1] = 4'd1; w[2] = 4'd2; w[3] = 4'd0;
    w[4] = 4'd7; w[5] = 4'd6; w[6] = 4'd5; w[7] = 4'd4;
    load_batch(1'b0, 1'b0);
    finish_batch(1'b0, -1, 1'b0);

    // Random batches on both instances.
    for (int b = 0; b < 6; b++) begin
      sel = 1'($urandom_range(0, 1));
      randomize_words();
      load_batch(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      finish_batch(sel, int'($urandom_range(0, 9)), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
